// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial subtractor: computes a - b one bit per clock, LSB first, with a
// ripple borrow held in a flop between cycles. The result is a (WIDTH+1)-bit
// two's-complement value whose top bit is the final borrow (1 = negative).
// Operands are zero-extended, so every result fits and there is no overflow.
//
// Handshake: start is sampled on a rising edge while the block is idle or
// has just completed (DONE). An accepted start captures a/b. busy is high for
// the WIDTH cycles of computation. done pulses high for exactly one cycle in
// the cycle that diff has just been updated. A start seen while busy is
// dropped, not queued. Holding start high in DONE chains the next operation
// with no idle cycle in between.
//
// Ports:
//   clk    - system clock, rising-edge active
//   rst_n  - asynchronous active-low reset
//   start  - request a new subtraction
//   a      - minuend (unsigned), captured on the accepted start edge
//   b      - subtrahend (unsigned), captured on the accepted start edge
//   busy   - operation in progress
//   done   - one-cycle pulse: diff has just been updated
//   diff   - a - b, two's complement, diff[WIDTH] = borrow-out / sign
// -----------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   diff
);

    // A 1-bit counter is still needed for WIDTH = 1 so the compare is legal.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] sa_q;
    logic [WIDTH-1:0] sb_q;
    logic [WIDTH-1:0] res_q;
    logic             br_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH:0]   diff_q;

    // One full-subtractor slice working on the current LSBs.
    logic             bit_d;
    logic             br_d;
    logic [WIDTH-1:0] res_d;

    always_comb begin
        bit_d = sa_q[0] ^ sb_q[0] ^ br_q;
        br_d  = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);
        // Each new bit enters at the MSB; after WIDTH shifts the first bit
        // computed has reached position 0, so the result is in normal order.
        res_d = (res_q >> 1) | (WIDTH'(bit_d) << (WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            diff_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    if (start) begin
                        sa_q    <= a;
                        sb_q    <= b;
                        res_q   <= '0;
                        br_q    <= 1'b0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end

                RUN: begin
                    // start is deliberately not looked at here.
                    sa_q  <= sa_q >> 1;
                    sb_q  <= sb_q >> 1;
                    res_q <= res_d;
                    br_q  <= br_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_BIT) begin
                        diff_q  <= {br_d, res_d};
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end

                DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        // Back-to-back: skip IDLE entirely.
                        sa_q    <= a;
                        sb_q    <= b;
                        res_q   <= '0;
                        br_q    <= 1'b0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end

                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//
// Drives a WIDTH=4 and a WIDTH=1 instance of serial_subtractor. Expected
// results come from plain integer subtraction reduced modulo 2^(WIDTH+1);
// expected timing comes from the start/done latency rules (done WIDTH cycles
// after the accepted start, one result per WIDTH+1 cycles when chained).
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUT: WIDTH = 4 ----------------
  logic       start4;
  logic [3:0] a4;
  logic [3:0] b4;
  logic       busy4;
  logic       done4;
  logic [4:0] diff4;

  serial_subtractor #(.WIDTH(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start4),
    .a     (a4),
    .b     (b4),
    .busy  (busy4),
    .done  (done4),
    .diff  (diff4)
  );

  // ---------------- DUT: WIDTH = 1 ----------------
  logic       start1;
  logic [0:0] a1;
  logic [0:0] b1;
  logic       busy1;
  logic       done1;
  logic [1:0] diff1;

  serial_subtractor #(.WIDTH(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start1),
    .a     (a1),
    .b     (b1),
    .busy  (busy1),
    .done  (done1),
    .diff  (diff1)
  );

  // ---------------- scoreboard ----------------
  int         n_checks;
  int         n_errors;
  logic [4:0] exp_q[$];
  logic [4:0] last4;   // value diff4 must hold until the next completion

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: zero-extended subtraction, wrapped to WIDTH+1 bits.
  function automatic logic [4:0] ref4(input logic [3:0] av, input logic [3:0] bv);
    int d;
    d = int'(av) - int'(bv);
    return d[4:0];
  endfunction

  function automatic logic [1:0] ref1(input logic [0:0] av, input logic [0:0] bv);
    int d;
    d = int'(av) - int'(bv);
    return d[1:0];
  endfunction

  // ---------------- driver tasks ----------------
  // Launch one WIDTH=4 operation and follow it to completion. Operands are
  // scrambled right after acceptance and a stray start may be raised mid-run;
  // neither may affect the result or the timing.
  task automatic op4(input logic [3:0] av, input logic [3:0] bv);
    int         n;
    logic [4:0] held;
    logic [4:0] exp;
    exp_q.push_back(ref4(av, bv));
    held   = last4;
    a4     = av;
    b4     = bv;
    start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    a4     = 4'($urandom);
    b4     = 4'($urandom);
    n      = 0;
    while (!done4 && n < 20) begin
      check_eq("busy_run", busy4, 1);
      check_eq("diff_hold", diff4, held);
      if (n == 1) start4 = 1'($urandom_range(0, 1));
      if (n == 2) start4 = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    check_eq("latency", n, 4);
    check_eq("done_pulse", done4, 1);
    check_eq("busy_at_done", busy4, 0);
    exp = exp_q.pop_front();
    check_eq("diff", diff4, exp);
    last4 = exp;
  endtask

  task automatic idle4(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      check_eq("idle_done", done4, 0);
      check_eq("idle_busy", busy4, 0);
      check_eq("idle_diff", diff4, last4);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    n_checks = 0;
    n_errors = 0;
    last4    = '0;
    rst_n    = 1'b0;
    start4   = 1'b0;
    a4       = '0;
    b4       = '0;
    start1   = 1'b0;
    a1       = '0;
    b1       = '0;

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy", busy4, 0);
    check_eq("rst_done", done4, 0);
    check_eq("rst_diff", diff4, 0);
    check_eq("rst_busy_w1", busy1, 0);
    check_eq("rst_diff_w1", diff1, 0);
    rst_n = 1'b1;
    idle4(1);

    // Directed cases, including equal operands and the most negative result.
    op4(4'd7,  4'd11); idle4(1);
    op4(4'd15, 4'd0);  idle4(1);
    op4(4'd0,  4'd15); idle4(1);
    op4(4'd5,  4'd5);  idle4(1);
    op4(4'd11, 4'd7);  idle4(2);
    op4(4'd2,  4'd9);  idle4(1);

    // start held high: chained results every WIDTH+1 cycles.
    a4     = 4'd9;
    b4     = 4'd3;
    start4 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      do begin
        @(posedge clk); #1;
        n++;
        if (n == 2) begin
          a4 = 4'($urandom);
          b4 = 4'($urandom);
        end
        if (n == 3) begin
          a4 = 4'd9;
          b4 = 4'd3;
        end
        if (!done4) check_eq("b2b_busy", busy4, 1);
      end while (!done4 && n < 20);
      check_eq("b2b_period", n, 5);
      check_eq("b2b_diff", diff4, ref4(4'd9, 4'd3));
    end
    start4 = 1'b0;
    last4  = ref4(4'd9, 4'd3);
    idle4(1);

    // Reset in the middle of an operation.
    a4     = 4'd3;
    b4     = 4'd1;
    start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_eq("pre_rst_busy", busy4, 1);
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_busy", busy4, 0);
    check_eq("async_rst_done", done4, 0);
    check_eq("async_rst_diff", diff4, 0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check_eq("no_done_in_rst", done4, 0);
    end
    rst_n = 1'b1;
    last4 = '0;
    idle4(2);
    op4(4'd3, 4'd1);
    idle4(1);

    // Randomized operations with random gaps (gap 0 = start in DONE).
    for (int i = 0; i < 30; i++) begin
      op4(4'($urandom), 4'($urandom));
      idle4($urandom_range(0, 2));
    end

    // WIDTH = 1: one-cycle RUN, all four operand pairs.
    for (int i = 0; i < 4; i++) begin
      a1     = 1'(i >> 1);
      b1     = 1'(i);
      start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      check_eq("w1_busy", busy1, 1);
      check_eq("w1_no_early_done", done1, 0);
      @(posedge clk); #1;
      check_eq("w1_done", done1, 1);
      check_eq("w1_diff", diff1, ref1(1'(i >> 1), 1'(i)));
      @(posedge clk); #1;
      check_eq("w1_done_low", done1, 0);
      check_eq("w1_busy_low", busy1, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
